ir_nec_rx: RTL and testbench
============================

// Module: ir_nec_rx
// PURPOSE
// - NEC IR remote decoder between the raw IR receiver pin and the core's GPIO/IRQ input.
// - Synchronises the demodulated pin, times mark/space periods in 10us ticks and decodes NEC frames and repeat codes.
// - Presents each decoded 32-bit frame through a single-entry valid/ready holding register.
// PARAMETERS
// - CLK_FREQ      50000000  clk_i frequency in Hz; tick divider = CLK_FREQ/100000 - 1
// - IR_ACTIVE_LOW 1         1: ir_i low = carrier present (mark); 0: ir_i high = mark
// PORTS
// - clk_i       in   1   single clock
// - rst_i       in   1   synchronous, active-high reset
// - ir_i        in   1   asynchronous demodulated IR pin
// - ready_i     in   1   consumer accepts data when valid_o=1
// - valid_o     out  1   holding register full
// - data_o      out  32  {~cmd,cmd,addr_hi,addr_lo}; first received bit = data_o[0]
// - repeat_o    out  1   1 = repeat code; data_o repeats last good frame
// - overflow_o  out  1   sticky: push dropped while full; cleared only by rst_i
// - busy_o      out  1   state != IDLE
// BEHAVIOUR
// - Reset values: valid_o=0, data_o=0, repeat_o=0, overflow_o=0, busy_o=0; FSM=IDLE; sync flops=idle level.
// - ir_i passes a 2-flop synchroniser, then an edge detector. Each edge resets the 10-bit duration counter (D).
// - D increments once per tick and saturates at 1023. Decisions are made on edges; edge-to-FSM latency is 3 clocks.
// - IDLE: mark start -> LEAD_MARK.
// - LEAD_MARK: mark end with D 800..1000 -> LEAD_SPACE; otherwise -> IDLE.
// - LEAD_SPACE at space end:
//   - D 400..500 -> BIT_MARK with bit count=0.
//   - D 200..250 -> STOP_MARK with rpt=1.
//   - otherwise -> IDLE.
// - BIT_MARK: mark end with D 40..70 -> BIT_SPACE; otherwise -> IDLE.
// - BIT_SPACE at space end:
//   - D 40..70 shifts in 0; D 140..200 shifts in 1 (LSB first, shift right into bit 31).
//   - Count 31 -> STOP_MARK with rpt=0; else -> BIT_MARK.
//   - Any other D -> IDLE, partial frame discarded.
// - STOP_MARK: mark end with D 40..70 -> push, then IDLE; otherwise -> IDLE with no push.
// - Timeout: D reaching 1023 in any non-IDLE state -> IDLE; this includes a stuck mark or space.
// - Push, rpt=0: shift register -> data_o; last_frame register updated; repeat_o=0.
// - Push, rpt=1: requires last_valid=1, else dropped silently; data_o=last_frame, repeat_o=1.
// - Push when valid_o=1 and ready_i=0: dropped; overflow_o<=1; data_o unchanged.
// - Push when valid_o=1 and ready_i=1 in the same cycle: new data loaded; valid_o stays 1.
// - valid_o & ready_i without push: valid_o<=0 next cycle. data_o is stable while valid_o=1.
// - rst_i mid-frame: all state cleared, including last_valid; the next frame decodes normally.
// CONFIGURATION
// - IR_NEC_CHECK_EN defined:
//   - rpt=0 push requires data[31:24] == ~data[23:16].
//   - On mismatch the frame is dropped and last_frame is not updated.
// - IR_NEC_CHECK_EN undefined: no integrity check; all 32 received bits are pushed raw.
// TESTING
// - Frame addr 0x00, ~addr 0xFF, cmd 0x45, ~cmd 0xBA at nominal timing -> one valid_o, data_o=0xBA45FF00, repeat_o=0.
// - Same frame, then 9ms mark + 2.25ms space + 560us mark -> second push: data_o=0xBA45FF00, repeat_o=1.
// - Repeat code after reset with no prior frame -> no valid_o; 300us leader mark -> no valid_o, busy_o back to 0.
// - Two frames with ready_i=0 -> data_o holds first, overflow_o=1. Then ready_i=1 -> valid_o=0 the next cycle.
// - With IR_NEC_CHECK_EN, cmd 0x45 and ~cmd 0xBB -> no push. Without it -> data_o=0xBB45FF00.
// - rst_i pulsed after bit 10 of a frame -> outputs at reset values; the next good frame decodes correctly.

Source files
------------

// File: rtl/ir_nec_rx.sv
// NEC IR remote decoder: synchronises the demodulated pin, times marks/spaces in 10us ticks,
// decodes frames and repeat codes into a valid/ready holding register. Define IR_NEC_CHECK_EN to drop frames whose ~cmd byte mismatches.
module ir_nec_rx #(
  parameter int CLK_FREQ      = 50000000,
  parameter bit IR_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ir_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        repeat_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int DIV = CLK_FREQ / 100000 - 1;
  localparam int TW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [TW-1:0] DIV_V = TW'(DIV);
  localparam logic IDLE_LVL = IR_ACTIVE_LOW;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LEAD_MARK  = 3'd1;
  localparam logic [2:0] LEAD_SPACE = 3'd2;
  localparam logic [2:0] BIT_MARK   = 3'd3;
  localparam logic [2:0] BIT_SPACE  = 3'd4;
  localparam logic [2:0] STOP_MARK  = 3'd5;

  logic          sync1_q, sync2_q, lvl_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [9:0]    dur_q, dur_d;
  logic [2:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          rpt_q, rpt_d;
  logic [31:0]   sr_q, sr_d;
  logic [31:0]   last_frame_q, last_frame_d;
  logic          last_valid_q, last_valid_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          repeat_q, repeat_d;
  logic          overflow_q, overflow_d;
  logic          tick, edge_w, mark_w, frame_ok, stop_ok, push_do;

  function automatic logic in_rng(input logic [9:0] d, input logic [9:0] lo, input logic [9:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign edge_w = sync2_q ^ lvl_q;
  assign mark_w = sync2_q ^ IDLE_LVL;
  assign tick   = (tick_cnt_q == DIV_V);

`ifdef IR_NEC_CHECK_EN
  assign frame_ok = (sr_q[31:24] == ~sr_q[23:16]);
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    if (edge_w)                          dur_d = '0;
    else if (tick && dur_q != 10'd1023)  dur_d = dur_q + 10'd1;
    else                                 dur_d = dur_q;
  end

  // Every edge is the end of the period the current state is waiting on, so D is that period's length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    sr_d    = sr_q;
    stop_ok = 1'b0;
    if (state_q != IDLE && dur_q == 10'd1023) begin
      state_d = IDLE;
    end else if (edge_w) begin
      case (state_q)
        IDLE:      if (mark_w) state_d = LEAD_MARK;
        LEAD_MARK: state_d = in_rng(dur_q, 10'd800, 10'd1000) ? LEAD_SPACE : IDLE;
        LEAD_SPACE: begin
          if (in_rng(dur_q, 10'd400, 10'd500)) begin
            state_d = BIT_MARK;
            cnt_d   = '0;
          end else if (in_rng(dur_q, 10'd200, 10'd250)) begin
            state_d = STOP_MARK;
            rpt_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        BIT_MARK:  state_d = in_rng(dur_q, 10'd40, 10'd70) ? BIT_SPACE : IDLE;
        BIT_SPACE: begin
          if (in_rng(dur_q, 10'd40, 10'd70) || in_rng(dur_q, 10'd140, 10'd200)) begin
            sr_d = {in_rng(dur_q, 10'd140, 10'd200), sr_q[31:1]};
            if (cnt_q == 5'd31) begin
              state_d = STOP_MARK;
              rpt_d   = 1'b0;
            end else begin
              state_d = BIT_MARK;
              cnt_d   = cnt_q + 5'd1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        STOP_MARK: begin
          stop_ok = in_rng(dur_q, 10'd40, 10'd70);
          state_d = IDLE;
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push_do      = stop_ok && (rpt_q ? last_valid_q : frame_ok);
    last_frame_d = last_frame_q;
    last_valid_d = last_valid_q;
    if (stop_ok && !rpt_q && frame_ok) begin
      last_frame_d = sr_q;
      last_valid_d = 1'b1;
    end
    valid_d    = valid_q;
    data_d     = data_q;
    repeat_d   = repeat_q;
    overflow_d = overflow_q;
    if (push_do) begin
      if (!valid_q || ready_i) begin
        valid_d  = 1'b1;
        data_d   = rpt_q ? last_frame_q : sr_q;
        repeat_d = rpt_q;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= IDLE_LVL;
      sync2_q      <= IDLE_LVL;
      lvl_q        <= IDLE_LVL;
      tick_cnt_q   <= '0;
      dur_q        <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      rpt_q        <= 1'b0;
      last_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      repeat_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= ir_i;
      sync2_q      <= sync1_q;
      lvl_q        <= sync2_q;
      tick_cnt_q   <= tick_cnt_d;
      dur_q        <= dur_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rpt_q        <= rpt_d;
      last_valid_q <= last_valid_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      repeat_q     <= repeat_d;
      overflow_q   <= overflow_d;
    end
  end

  // Shift register and last-frame copy are qualified by FSM/last_valid state, so they need no reset.
  always_ff @(posedge clk_i) begin
    sr_q         <= sr_d;
    last_frame_q <= last_frame_d;
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign repeat_o   = repeat_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx; CLK_FREQ=100000 gives one 10us tick per clock.
module tb_ir_nec_rx;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ir_i = 1'b1;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] data_o;
  logic        repeat_o;
  logic        overflow_o;
  logic        busy_o;

  int vecs = 0;
  int errs = 0;

  localparam logic [31:0] FA = 32'hBA45FF00;
  localparam logic [31:0] FB = 32'hF708FB04;
  localparam logic [31:0] FC = 32'hBB45FF00;

  ir_nec_rx #(.CLK_FREQ(100000), .IR_ACTIVE_LOW(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .ready_i(ready_i),
    .valid_o(valid_o), .data_o(data_o), .repeat_o(repeat_o),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    ir_i = lvl;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bits(input logic [31:0] f, input int nbits);
    hold(1'b0, 900);
    hold(1'b1, 450);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 56);
      hold(1'b1, f[i] ? 169 : 56);
    end
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_bits(f, 32);
    hold(1'b0, 56);
    hold(1'b1, 20);
  endtask

  task automatic send_repeat();
    hold(1'b0, 900);
    hold(1'b1, 225);
    hold(1'b0, 56);
    hold(1'b1, 20);
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    hold(1'b1, 3);
    rst_i = 1'b0;
    hold(1'b1, 2);
  endtask

  initial begin
    do_reset();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_repeat", {31'd0, repeat_o}, 32'd0);
    check("rst_overflow", {31'd0, overflow_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);

    send_frame(FA);
    check("frameA_valid", {31'd0, valid_o}, 32'd1);
    check("frameA_data", data_o, FA);
    check("frameA_repeat", {31'd0, repeat_o}, 32'd0);
    check("frameA_busy", {31'd0, busy_o}, 32'd0);
    consume();
    check("frameA_consumed", {31'd0, valid_o}, 32'd0);

    send_repeat();
    check("rptA_valid", {31'd0, valid_o}, 32'd1);
    check("rptA_data", data_o, FA);
    check("rptA_repeat", {31'd0, repeat_o}, 32'd1);
    consume();

    hold(1'b0, 1100);
    check("timeout_busy", {31'd0, busy_o}, 32'd0);
    hold(1'b1, 20);

    do_reset();
    send_repeat();
    check("rpt_noprior_valid", {31'd0, valid_o}, 32'd0);
    hold(1'b0, 10);
    check("short_lead_busy_mid", {31'd0, busy_o}, 32'd1);
    hold(1'b0, 20);
    hold(1'b1, 10);
    check("short_lead_busy", {31'd0, busy_o}, 32'd0);
    check("short_lead_valid", {31'd0, valid_o}, 32'd0);

    send_frame(FA);
    send_frame(FB);
    check("ovf_valid", {31'd0, valid_o}, 32'd1);
    check("ovf_data", data_o, FA);
    check("ovf_flag", {31'd0, overflow_o}, 32'd1);
    consume();
    check("ovf_consumed", {31'd0, valid_o}, 32'd0);
    check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    send_frame(FC);
`ifdef IR_NEC_CHECK_EN
    check("badcmd_valid", {31'd0, valid_o}, 32'd0);
    check("badcmd_data", data_o, FA);
`else
    check("badcmd_valid", {31'd0, valid_o}, 32'd1);
    check("badcmd_data", data_o, FC);
    consume();
`endif

    send_bits(FA, 10);
    do_reset();
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_data", data_o, 32'd0);
    check("midrst_overflow", {31'd0, overflow_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_repeat", {31'd0, repeat_o}, 32'd0);
    send_frame(FB);
    check("postrst_valid", {31'd0, valid_o}, 32'd1);
    check("postrst_data", data_o, FB);
    check("postrst_repeat", {31'd0, repeat_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
